// File: rtl/date_set_sequencer.sv
// date_set_sequencer: manual-adjust front end for the century clock.
// On start, steps each BCD field (year, mon, day, hour, min, sec) toward a
// latched target using single-cycle up/down pulses, then reports done or a
// per-field timeout through error/err_field.
// Optional feature: define SHORTEST_PATH_EN to pick the shorter modular
// direction for sec, min, hour and mon (day and year stay direct compare).
module date_set_sequencer #(
    parameter int SETTLE_CYC = 2,
    parameter int MAX_STEPS  = 10000,
    parameter int STEP_W     = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  tgt_sec,
    input  logic [7:0]  tgt_min,
    input  logic [7:0]  tgt_hour,
    input  logic [7:0]  tgt_day,
    input  logic [7:0]  tgt_mon,
    input  logic [15:0] tgt_year,
    input  logic [7:0]  cur_sec,
    input  logic [7:0]  cur_min,
    input  logic [7:0]  cur_hour,
    input  logic [7:0]  cur_day,
    input  logic [7:0]  cur_mon,
    input  logic [15:0] cur_year,
    output logic        up_s,
    output logic        down_s,
    output logic        up_m,
    output logic        down_m,
    output logic        up_h,
    output logic        down_h,
    output logic        up_d,
    output logic        down_d,
    output logic        up_mo,
    output logic        down_mo,
    output logic        up_y,
    output logic        down_y,
    output logic        en_s_gate,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_field
);

    localparam int SET_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;

    // Field index doubles as the err_field code: 0=year ... 5=sec
    localparam logic [2:0] F_YEAR = 3'd0;
    localparam logic [2:0] F_SEC  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_PULSE,
        S_SETTLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    logic [2:0]        field;
    logic [STEP_W-1:0] step;
    logic [SET_W-1:0]  settle_cnt;

    logic [7:0]        t_sec, t_min, t_hour, t_day, t_mon;
    logic [15:0]       t_year;

    // Bit i of each vector drives the pulse for field index i
    logic [5:0]        up_v, dn_v;

    logic [15:0]       cur_f, tgt_f;
    logic              go_up;

    assign up_y    = up_v[0];
    assign up_mo   = up_v[1];
    assign up_d    = up_v[2];
    assign up_h    = up_v[3];
    assign up_m    = up_v[4];
    assign up_s    = up_v[5];
    assign down_y  = dn_v[0];
    assign down_mo = dn_v[1];
    assign down_d  = dn_v[2];
    assign down_h  = dn_v[3];
    assign down_m  = dn_v[4];
    assign down_s  = dn_v[5];

    // Select the live and target value of the field currently being adjusted
    always_comb begin
        cur_f = '0;
        tgt_f = '0;
        case (field)
            3'd0:    begin cur_f = cur_year;          tgt_f = t_year;          end
            3'd1:    begin cur_f = {8'h00, cur_mon};  tgt_f = {8'h00, t_mon};  end
            3'd2:    begin cur_f = {8'h00, cur_day};  tgt_f = {8'h00, t_day};  end
            3'd3:    begin cur_f = {8'h00, cur_hour}; tgt_f = {8'h00, t_hour}; end
            3'd4:    begin cur_f = {8'h00, cur_min};  tgt_f = {8'h00, t_min};  end
            default: begin cur_f = {8'h00, cur_sec};  tgt_f = {8'h00, t_sec};  end
        endcase
    end

`ifdef SHORTEST_PATH_EN
    function automatic logic [7:0] bcd2bin(input logic [7:0] b);
        return ({4'd0, b[7:4]} * 8'd10) + {4'd0, b[3:0]};
    endfunction

    logic signed [9:0] sp_mod, sp_diff, sp_dist;
    logic              sp_wrap;

    // Direction choice: shorter modular distance for wrapping fields, ties up.
    // Month's 1..12 offset cancels in the difference, so no rebasing is needed.
    always_comb begin
        sp_wrap = 1'b1;
        sp_mod  = 10'sd60;
        case (field)
            3'd1:      sp_mod = 10'sd12;
            3'd3:      sp_mod = 10'sd24;
            3'd4, 3'd5: sp_mod = 10'sd60;
            default:   sp_wrap = 1'b0;
        endcase
        sp_diff = $signed({2'b00, bcd2bin(tgt_f[7:0])}) - $signed({2'b00, bcd2bin(cur_f[7:0])});
        sp_dist = (sp_diff < 0) ? (sp_diff + sp_mod) : sp_diff;
        go_up   = sp_wrap ? ((sp_dist <<< 1) <= sp_mod) : (tgt_f > cur_f);
    end
`else
    // Direction choice: packed-BCD unsigned compare orders like binary
    always_comb begin
        go_up = (tgt_f > cur_f);
    end
`endif

    // Sequencer FSM with registered pulse and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            field      <= F_YEAR;
            step       <= '0;
            settle_cnt <= '0;
            t_sec      <= '0;
            t_min      <= '0;
            t_hour     <= '0;
            t_day      <= '0;
            t_mon      <= '0;
            t_year     <= '0;
            up_v       <= '0;
            dn_v       <= '0;
            en_s_gate  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_field  <= '0;
        end else begin
            up_v <= '0;
            dn_v <= '0;
            done <= 1'b0;
            if (abort) begin
                if (state != S_IDLE) begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    en_s_gate <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            t_sec     <= tgt_sec;
                            t_min     <= tgt_min;
                            t_hour    <= tgt_hour;
                            t_day     <= tgt_day;
                            t_mon     <= tgt_mon;
                            t_year    <= tgt_year;
                            busy      <= 1'b1;
                            en_s_gate <= 1'b0;
                            error     <= 1'b0;
                            field     <= F_YEAR;
                            step      <= '0;
                            state     <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (cur_f == tgt_f) begin
                            step <= '0;
                            if (field == F_SEC) begin
                                state <= S_DONE;
                            end else begin
                                field <= field + 3'd1;
                            end
                        end else if (step == STEP_W'(MAX_STEPS)) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_PULSE;
                        end
                    end
                    S_PULSE: begin
                        if (go_up) begin
                            up_v <= 6'b000001 << field;
                        end else begin
                            dn_v <= 6'b000001 << field;
                        end
                        step       <= step + 1'b1;
                        settle_cnt <= '0;
                        state      <= (SETTLE_CYC == 0) ? S_CHECK : S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                            state <= S_CHECK;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        en_s_gate <= 1'b1;
                        state     <= S_IDLE;
                    end
                    S_ERR: begin
                        error     <= 1'b1;
                        err_field <= field;
                        busy      <= 1'b0;
                        en_s_gate <= 1'b1;
                        state     <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
